// File: rtl/lsu.sv
// Load/store unit: single-outstanding data-bus access with lane steering,
// load extraction, alignment checking and a request timeout.
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] reg_out,
  input  logic            mm_we,
  input  logic            passthrough,
  input  logic [2:0]      funct3,
  output logic            stall,
  output logic [XLEN-1:0] rd_data,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic [XLEN-1:0] dbus_rdata,
  input  logic            dbus_ack,
  output logic            fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic [XLEN-1:0] r_rd_data;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_be;
  logic            r_fault;
  logic            w_mem;
  logic            w_ok;

  // Legal encoding and natural alignment for the requested access size.
  function automatic logic f_ok(input logic [2:0] f3, input logic we, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000, 3'b100: ok = !(we && f3[2]);
      3'b001, 3'b101: ok = !(we && f3[2]) && !off[0];
      3'b010:         ok = (off == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b100:  v = {24'h000000, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b101:  v = {16'h0000, h};
      default: v = rd;
    endcase
    return v;
  endfunction

  assign w_mem = valid && !passthrough;
  assign w_ok  = f_ok(funct3, mm_we, result[1:0]);

  // Hold the execute stage while an access is being accepted or is waiting for ack.
  always_comb begin
    stall = 1'b0;
    if (!rst_n) begin
      stall = 1'b0;
    end else if (r_state == S_REQ) begin
      stall = !dbus_ack;
    end else begin
      stall = w_mem && w_ok;
    end
  end

  // Access sequencing, bus output registers and write-back data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_f3      <= 3'b000;
      r_off     <= 2'b00;
      r_rd_data <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= 4'b0000;
      r_fault   <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            if (passthrough) begin
              r_rd_data <= result;
            end else if (w_ok) begin
              r_state <= S_REQ;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_we    <= mm_we;
              r_addr  <= {result[XLEN-1:2], 2'b00};
              r_be    <= f_be(funct3, result[1:0]);
              r_wdata <= mm_we ? f_wdata(funct3, reg_out) : '0;
              r_f3    <= funct3;
              r_off   <= result[1:0];
            end else begin
              r_fault   <= 1'b1;
              r_rd_data <= '0;
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over the timeout expiring in the same cycle.
          if (dbus_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (!r_we) begin
              r_rd_data <= f_extract(r_f3, r_off, dbus_rdata);
            end
          end else if (r_cnt == C_LAST) begin
            r_state   <= S_IDLE;
            r_cnt     <= r_cnt + 1'b1;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_fault   <= 1'b1;
            r_rd_data <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign dbus_req   = r_req;
  assign dbus_we    = r_we;
  assign dbus_addr  = r_addr;
  assign dbus_wdata = r_wdata;
  assign dbus_be    = r_be;
  assign fault      = r_fault;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_lsu;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n, valid, mm_we, passthrough, dbus_ack;
  logic [31:0] result, reg_out, dbus_rdata;
  logic [2:0]  funct3;
  logic        stall, dbus_req, dbus_we, fault;
  logic [31:0] rd_data, dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;

  int checks = 0;
  int errors = 0;

  lsu #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .result(result), .reg_out(reg_out),
    .mm_we(mm_we), .passthrough(passthrough), .funct3(funct3), .stall(stall),
    .rd_data(rd_data), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = int'(f3[1:0]);
    if (sz == 3) return 1'b0;
    if (st && f3[2]) return 1'b0;
    if (f3 == 3'b110) return 1'b0;
    return (a % (32'd1 << sz)) == 32'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [7:0] t;
    n = 1 << int'(f3[1:0]);
    t = 8'(((1 << n) - 1) << (a % 4));
    return t[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return 32'({24'h0, d[7:0]} * 32'h01010101);
    if (f3[1:0] == 2'b01) return 32'({16'h0, d[15:0]} * 32'h00010001);
    return d;
  endfunction

  function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (f3[1:0] == 2'b00) return f3[2] ? {24'h0, v[7:0]} : 32'($signed(v[7:0]));
    if (f3[1:0] == 2'b01) return f3[2] ? {16'h0, v[15:0]} : 32'($signed(v[15:0]));
    return rd;
  endfunction

  bit          m_busy, m_store, e_fault;
  int          m_wait;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_data, e_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_store <= 1'b0; e_fault <= 1'b0; m_wait <= 0;
      m_f3 <= 3'b000; m_addr <= 32'h0; m_data <= 32'h0; e_rd <= 32'h0;
    end else begin
      e_fault <= 1'b0;
      if (!m_busy) begin
        if (valid && passthrough) begin
          e_rd <= result;
        end else if (valid && m_legal(mm_we, funct3, result)) begin
          m_busy <= 1'b1; m_wait <= 0; m_store <= mm_we;
          m_f3 <= funct3; m_addr <= result; m_data <= reg_out;
        end else if (valid) begin
          e_fault <= 1'b1; e_rd <= 32'h0;
        end
      end else if (dbus_ack) begin
        m_busy <= 1'b0;
        if (!m_store) e_rd <= m_extract(m_f3, m_addr, dbus_rdata);
      end else if (m_wait + 1 == TIMEOUT) begin
        m_busy <= 1'b0; e_fault <= 1'b1; e_rd <= 32'h0; m_wait <= m_wait + 1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  // Per-cycle compare of DUT against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_req", 32'(dbus_req), 32'h0);
      chk("rst_rd", rd_data, 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_addr", dbus_addr, 32'h0);
      chk("rst_be", 32'(dbus_be), 32'h0);
    end else begin
      chk("stall", 32'(stall), m_busy ? 32'(!dbus_ack)
          : 32'(valid && !passthrough && m_legal(mm_we, funct3, result)));
      chk("rd_data", rd_data, e_rd);
      chk("fault", 32'(fault), 32'(e_fault));
      chk("dbus_req", 32'(dbus_req), 32'(m_busy));
      chk("dbus_we", 32'(dbus_we), 32'(m_busy && m_store));
      if (m_busy) begin
        chk("dbus_addr", dbus_addr, {m_addr[31:2], 2'b00});
        chk("dbus_be", 32'(dbus_be), 32'(m_be(m_f3, m_addr)));
        if (m_store) chk("dbus_wdata", dbus_wdata, m_wdata(m_f3, m_data));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          t_stalls;
  bit          t_req, t_we, t_fault;
  logic [31:0] t_addr, t_wdata, t_rd;
  logic [3:0]  t_be;

  task automatic run_op(input bit p, input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int ack_at, input logic [31:0] rdata);
    @(posedge clk); #1;
    valid = 1'b1; passthrough = p; mm_we = w; funct3 = f3; result = a; reg_out = d;
    dbus_ack = 1'b0; dbus_rdata = rdata;
    t_stalls = 0; t_req = 1'b0;
    @(negedge clk);
    if (stall) t_stalls++;
    if (dbus_req) t_req = 1'b1;
    if (!p && m_legal(w, f3, a)) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(posedge clk); #1;
        dbus_ack = (k == ack_at);
        @(negedge clk);
        if (stall) t_stalls++;
        if (dbus_req) t_req = 1'b1;
        if (k == 1) begin
          t_addr = dbus_addr; t_be = dbus_be; t_wdata = dbus_wdata; t_we = dbus_we;
        end
        if (k == ack_at) break;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; passthrough = 1'b0; mm_we = 1'b0; dbus_ack = 1'b0;
    @(negedge clk);
    t_fault = fault; t_rd = rd_data;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; mm_we = 1'b0; passthrough = 1'b0; dbus_ack = 1'b0;
    result = 32'h0; reg_out = 32'h0; dbus_rdata = 32'h0; funct3 = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b1, 1'b0, 3'b000, 32'h12345678, 32'h0, 0, 32'h0);
    chk("pass_rd", t_rd, 32'h12345678);
    chk("pass_stall", 32'(t_stalls), 32'd0);

    run_op(1'b0, 1'b0, 3'b000, 32'h00001003, 32'h0, 4, 32'h80FFFFFF);
    chk("lb_addr", t_addr, 32'h00001000);
    chk("lb_be", 32'(t_be), 32'h8);
    chk("lb_rd", t_rd, 32'hFFFFFF80);
    chk("lb_stalls", 32'(t_stalls), 32'd4);

    run_op(1'b0, 1'b1, 3'b001, 32'h00002002, 32'hAAAABEEF, 1, 32'h0);
    chk("sh_be", 32'(t_be), 32'hC);
    chk("sh_wdata", t_wdata, 32'hBEEFBEEF);
    chk("sh_we", 32'(t_we), 32'h1);
    chk("sh_rd_kept", t_rd, 32'hFFFFFF80);

    run_op(1'b0, 1'b0, 3'b010, 32'h00003001, 32'h0, 1, 32'h0);
    chk("lw_mis_req", 32'(t_req), 32'h0);
    chk("lw_mis_fault", 32'(t_fault), 32'h1);
    chk("lw_mis_rd", t_rd, 32'h0);

    run_op(1'b0, 1'b0, 3'b101, 32'h00004000, 32'h0, 0, 32'h55555555);
    chk("to_fault", 32'(t_fault), 32'h1);
    chk("to_stalls", 32'(t_stalls), 32'd17);
    chk("to_rd", t_rd, 32'h0);

    run_op(1'b0, 1'b0, 3'b101, 32'h00004000, 32'h0, 16, 32'h1234ABCD);
    chk("ack16_fault", 32'(t_fault), 32'h0);
    chk("ack16_rd", t_rd, 32'h0000ABCD);

    run_op(1'b0, 1'b0, 3'b001, 32'h00004002, 32'h0, 1, 32'h80010000);
    chk("lh_rd", t_rd, 32'hFFFF8001);
    run_op(1'b0, 1'b0, 3'b100, 32'h00004001, 32'h0, 2, 32'h00009A00);
    chk("lbu_rd", t_rd, 32'h0000009A);
    run_op(1'b0, 1'b1, 3'b000, 32'h00005001, 32'h123456C3, 1, 32'h0);
    chk("sb_be", 32'(t_be), 32'h2);
    chk("sb_wdata", t_wdata, 32'hC3C3C3C3);
    run_op(1'b0, 1'b1, 3'b010, 32'h00006000, 32'hDEADBEEF, 3, 32'h0);
    chk("sw_be", 32'(t_be), 32'hF);
    chk("sw_wdata", t_wdata, 32'hDEADBEEF);
    run_op(1'b0, 1'b1, 3'b100, 32'h00007000, 32'h0, 1, 32'h0);
    chk("st_ill_fault", 32'(t_fault), 32'h1);
    run_op(1'b0, 1'b0, 3'b011, 32'h00007000, 32'h0, 1, 32'h0);
    chk("ld_ill_req", 32'(t_req), 32'h0);
    run_op(1'b0, 1'b1, 3'b001, 32'h00002001, 32'h0, 1, 32'h0);
    chk("sh_mis_fault", 32'(t_fault), 32'h1);

    // Reset in the middle of an outstanding load, then a late ack.
    @(posedge clk); #1;
    valid = 1'b1; mm_we = 1'b0; passthrough = 1'b0; funct3 = 3'b010; result = 32'h00008000;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0; valid = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dbus_req), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_addr", dbus_addr, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'h00000BAD;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rd", rd_data, 32'h0);
    chk("late_ack_req", 32'(dbus_req), 32'h0);
    run_op(1'b0, 1'b0, 3'b010, 32'h00008004, 32'h0, 1, 32'hCAFEF00D);
    chk("post_rst_lw", t_rd, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
